mem_wb_stage_pipelined: RTL
===========================

Name: mem_wb_stage_pipelined

Overview:
Parametrised memory stage with a built-in MEM/WB pipeline register, for the pipelined RISC core.
- Accepts one instruction per cycle from EX/MEM and performs a load or store on an internal data memory with configurable wait states.
- Back-pressures EX with a stall while an access is outstanding.
- Presents the selected register write-back value, registered, to the WB stage.

Parameters:
DATA_W, 16, data/register width in bits
ADDR_W, 16, width of alu_out used as address
DEPTH, 256, data memory words (power of two); address index = alu_out[log2(DEPTH)-1:0]
MEM_LAT, 1, extra wait cycles per memory access (0..7)

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high
valid_in  in  1  EX/MEM holds a valid instruction
flush  in  1  kill the instruction in this stage (branch mispredict)
alu_out  in  ADDR_W  address for memory ops / ALU result
store_data  in  DATA_W  rf_d2 value to store
mem_read  in  1  instruction is a load
mem_write  in  1  instruction is a store
reg_dst  in  2  write-back select: 0 alu_out, 1 memory data, 2 imm9_ls7, 3 pc_current
imm9_ls7  in  DATA_W  immediate shifted left 7
pc_current  in  DATA_W  PC of the instruction
rf_we_in  in  1  instruction writes the register file
rf_waddr_in  in  3  destination register
stall  out  1  stage busy; EX/MEM must hold its outputs
valid_out  out  1  MEM/WB register holds a valid instruction
reg_write_value  out  DATA_W  registered write-back value
mem_data_out  out  DATA_W  registered load data (0 for non-loads)
rf_we_out  out  1  registered rf_we_in, gated by valid_out
rf_waddr_out  out  3  registered destination register

Behaviour:
- Reset (synchronous, high): FSM to IDLE; stall, valid_out, rf_we_out = 0; reg_write_value, mem_data_out, rf_waddr_out = 0. Memory contents are not cleared.
- Reset mid-access aborts the access. A pending store is not written.
- FSM states: IDLE, WAIT. Transaction is accepted when valid_in=1 and stall=0.
- Non-memory op (mem_read=mem_write=0): latched into MEM/WB on the accept edge; valid_out=1 on the next cycle. Latency 1, throughput 1/cycle.
- Memory op with MEM_LAT=0: single-cycle access. Load data is read asynchronously at the index and registered with the result. Store is written on the accept edge. stall is never asserted.
- Memory op with MEM_LAT=N>0:
  - Accept edge: IDLE->WAIT; capture the instruction; counter = N.
  - stall=1 combinationally while in WAIT; valid_out=0 during WAIT.
  - Counter decrements each cycle. On the edge where counter==1: store commits / load data is captured, MEM/WB updated, WAIT->IDLE.
  - Total latency N+1 cycles.
- Back-to-back: a new instruction is accepted in the same cycle the FSM returns to IDLE; the EX/MEM hold contract makes this safe.
- mem_read and mem_write both 1 is illegal; treat it as a store and drive 0 on mem_data_out.
- reg_write_value mux: 0 alu_out (zero-extended/truncated to DATA_W), 1 memory read data, 2 imm9_ls7, 3 pc_current.
- flush:
  - In IDLE: the current input is not accepted; valid_out=0 next cycle.
  - In WAIT: abort to IDLE; the store is suppressed if not yet committed; valid_out stays 0; stall drops next cycle.
  - flush on the commit edge: flush wins; no write, no valid_out.
- Any edge without a completing transaction: valid_out=0, rf_we_out=0; other registered outputs hold.
- Address wrap: index uses the low log2(DEPTH) bits; e.g. with DEPTH=256, 0x0105 aliases 0x0005.
- Read-during-write to the same index on one edge returns the old data (write-first is not required).

Decomposition:
- Shared package/header: reg_dst encodings (WB_ALU=0, WB_MEM=1, WB_IMM=2, WB_PC=3), FSM state encodings, register-address width 3.
- One sub-module: data_memory_param (DATA_W, DEPTH; async read, sync write, no reset on the array).
- FSM, counter, write-back mux and MEM/WB register live in the top module.

Test Plan:
- Reset: assert reset 2 cycles mid-WAIT of a store 0xBEEF to 0x10 -> all outputs 0, FSM IDLE, a later load of 0x10 returns the old value.
- MEM_LAT=2: store 0x1234 to 0x20, then load 0x20 with reg_dst=1 -> stall high 2 cycles per op; valid_out one cycle per op; reg_write_value=0x1234 three cycles after load accept.
- Non-memory stream: 4 back-to-back ops with reg_dst=0,2,3,0 -> stall never high; valid_out every cycle; values alu_out, imm9_ls7, pc_current, alu_out in order.
- Flush on commit edge of a store 0x5555 to 0x30 -> no valid_out; a later load of 0x30 returns the prior contents.
- Address wrap, DEPTH=256: store 0xA5A5 to 0x0105, load 0x0005 -> 0xA5A5.
- MEM_LAT=0: alternating store/load to 0x40 each cycle -> stall stays 0; the load returns the stored value one cycle after its accept.

Source files
------------

// File: rtl/mem_wb_stage_pipelined_pkg.sv
// Shared definitions for the memory stage and its MEM/WB pipeline register.
//   - write-back source select encodings carried on reg_dst
//   - FSM state encodings for the access sequencer
//   - register-file address width
package mem_wb_stage_pipelined_pkg;

  localparam int RADDR_W = 3;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_IMM = 2'd2;
  localparam logic [1:0] WB_PC  = 2'd3;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

endpackage

// File: rtl/mem_wb_stage_pipelined_data_memory.sv
// Data memory for the memory stage: combinational read, write on the rising
// clock edge, no reset on the array (contents survive a core reset).
// A read that coincides with a write to the same word returns the old data.
// Ports:
//   clk    in   clock
//   we     in   write enable
//   addr   in   word index, log2(DEPTH) bits
//   wdata  in   write data, DATA_W bits
//   rdata  out  read data at addr, DATA_W bits
module data_memory_param #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 256
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_wb_stage_pipelined.sv
// Memory stage of the pipelined RISC core with its MEM/WB pipeline register.
// Performs one load or store per accepted instruction on an internal data
// memory with MEM_LAT wait cycles, stalls EX while an access is outstanding
// and registers the selected write-back value for the WB stage.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   valid_in, flush            instruction present / kill instruction in stage
//   alu_out, store_data        address or ALU result / data to store
//   mem_read, mem_write        load / store (both set is treated as a store)
//   reg_dst                    write-back source select (WB_* encodings)
//   imm9_ls7, pc_current       alternative write-back sources
//   rf_we_in, rf_waddr_in      register-file write enable / destination
//   stall                      stage busy, EX/MEM must hold
//   valid_out                  MEM/WB register holds a completed instruction
//   reg_write_value            registered write-back value
//   mem_data_out               registered load data (0 for non-loads)
//   rf_we_out, rf_waddr_out    registered register-file write controls
module mem_wb_stage_pipelined
  import mem_wb_stage_pipelined_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int DEPTH   = 256,
  parameter int MEM_LAT = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               valid_in,
  input  logic               flush,
  input  logic [ADDR_W-1:0]  alu_out,
  input  logic [DATA_W-1:0]  store_data,
  input  logic               mem_read,
  input  logic               mem_write,
  input  logic [1:0]         reg_dst,
  input  logic [DATA_W-1:0]  imm9_ls7,
  input  logic [DATA_W-1:0]  pc_current,
  input  logic               rf_we_in,
  input  logic [RADDR_W-1:0] rf_waddr_in,
  output logic               stall,
  output logic               valid_out,
  output logic [DATA_W-1:0]  reg_write_value,
  output logic [DATA_W-1:0]  mem_data_out,
  output logic               rf_we_out,
  output logic [RADDR_W-1:0] rf_waddr_out
);

  localparam int         IDX_W = $clog2(DEPTH);
  localparam logic [2:0] LAT   = 3'(MEM_LAT);

  function automatic logic [DATA_W-1:0] fit_alu(input logic [ADDR_W-1:0] a);
    return DATA_W'(a);
  endfunction

  function automatic logic [DATA_W-1:0] wb_select(
    input logic [1:0]        sel,
    input logic [DATA_W-1:0] alu,
    input logic [DATA_W-1:0] ld,
    input logic [DATA_W-1:0] imm,
    input logic [DATA_W-1:0] pc
  );
    case (sel)
      WB_ALU:  return alu;
      WB_MEM:  return ld;
      WB_IMM:  return imm;
      default: return pc;
    endcase
  endfunction

  logic [0:0] state;
  logic [2:0] cnt;

  // p0: instruction captured on the accept edge of a multi-cycle access
  logic [ADDR_W-1:0]  addr_p0;
  logic [DATA_W-1:0]  sdata_p0;
  logic [DATA_W-1:0]  imm_p0;
  logic [DATA_W-1:0]  pc_p0;
  logic               rd_p0;
  logic               wr_p0;
  logic [1:0]         sel_p0;
  logic               we_p0;
  logic [RADDR_W-1:0] waddr_p0;

  logic in_wait, accept, go_wait, done;
  logic [ADDR_W-1:0]  cur_addr;
  logic [DATA_W-1:0]  cur_sdata, cur_imm, cur_pc, rdata, ld_data;
  logic               cur_rd, cur_wr, cur_we, mem_we;
  logic [1:0]         cur_sel;
  logic [RADDR_W-1:0] cur_waddr;

  assign in_wait = (state == ST_WAIT);
  assign stall   = in_wait;
  assign accept  = valid_in && !stall && !flush;
  // Memory ops only enter WAIT when wait states are configured
  assign go_wait = accept && (mem_read || mem_write) && (MEM_LAT != 0);
  // An instruction completes either on its accept edge (single-cycle path)
  // or on the last WAIT edge, unless flushed on that edge
  assign done    = (accept && !go_wait) || (in_wait && !flush && cnt == 3'd1);

  // The completing instruction comes from the capture registers in WAIT,
  // straight from EX/MEM otherwise
  assign cur_addr  = in_wait ? addr_p0  : alu_out;
  assign cur_sdata = in_wait ? sdata_p0 : store_data;
  assign cur_imm   = in_wait ? imm_p0   : imm9_ls7;
  assign cur_pc    = in_wait ? pc_p0    : pc_current;
  assign cur_rd    = in_wait ? rd_p0    : mem_read;
  assign cur_wr    = in_wait ? wr_p0    : mem_write;
  assign cur_sel   = in_wait ? sel_p0   : reg_dst;
  assign cur_we    = in_wait ? we_p0    : rf_we_in;
  assign cur_waddr = in_wait ? waddr_p0 : rf_waddr_in;

  // Reset on the commit edge must also suppress the store
  assign mem_we  = done && cur_wr && !reset;
  // Read and write both set behaves as a store: no load data
  assign ld_data = (cur_rd && !cur_wr) ? rdata : '0;

  data_memory_param #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_dmem (
    .clk   (clk),
    .we    (mem_we),
    .addr  (cur_addr[IDX_W-1:0]),
    .wdata (cur_sdata),
    .rdata (rdata)
  );

  // FSM, wait counter and MEM/WB register
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= ST_IDLE;
      cnt             <= 3'd0;
      valid_out       <= 1'b0;
      rf_we_out       <= 1'b0;
      reg_write_value <= '0;
      mem_data_out    <= '0;
      rf_waddr_out    <= '0;
    end else begin
      if (go_wait) begin
        state <= ST_WAIT;
        cnt   <= LAT;
      end else if (in_wait && (flush || cnt == 3'd1)) begin
        state <= ST_IDLE;
      end else if (in_wait) begin
        cnt <= cnt - 3'd1;
      end
      valid_out <= done;
      rf_we_out <= done && cur_we;
      if (done) begin
        reg_write_value <= wb_select(cur_sel, fit_alu(cur_addr), ld_data, cur_imm, cur_pc);
        mem_data_out    <= ld_data;
        rf_waddr_out    <= cur_waddr;
      end
    end
  end

  // Capture registers hold data only, so they need no reset
  always_ff @(posedge clk) begin
    if (go_wait) begin
      addr_p0  <= alu_out;
      sdata_p0 <= store_data;
      imm_p0   <= imm9_ls7;
      pc_p0    <= pc_current;
      rd_p0    <= mem_read;
      wr_p0    <= mem_write;
      sel_p0   <= reg_dst;
      we_p0    <= rf_we_in;
      waddr_p0 <= rf_waddr_in;
    end
  end

endmodule
